instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Front-end fetch stage of the RISC-V core: owns the program counter, drives the word address into the combinational instruction memory, and buffers fetched instructions with their PCs in a small queue. The queue feeds the decode stage over a valid/ready handshake. Branch/jump redirects from execute flush the queue and reload the PC. It sits directly upstream of the instruction memory (address side) and directly downstream of it (data side).

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] must be 0.
- QUEUE_DEPTH, 2, fetch queue entries; power of two, 2..8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  word index to instruction memory, equal to pc >> 2 (zero-extended).
- imem_rdata  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  execute requests PC redirect this cycle.
- redirect_pc  in  32  redirect target byte address; bits [1:0] ignored (forced to 0).
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  32  instruction at queue head; 0 when id_valid=0.
- id_pc  out  32  byte PC of id_instr; 0 when id_valid=0.

## Operation

- State: pc (32b, bits [1:0] always 0), queue of QUEUE_DEPTH entries {pc, instr}, read pointer, write pointer, occupancy count (0..QUEUE_DEPTH).
- pop = id_valid & id_ready.
- fetch_en = !redirect_valid & ((count < QUEUE_DEPTH) | pop).
- fetch_en: push {pc, imem_rdata} at write pointer; pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
- fetch_en=0 and no redirect: pc holds; imem_addr holds.
- Push and pop in the same cycle: count unchanged, both pointers advance; legal when full.
- Pop with no push: count decrements; id outputs advance to next entry.
- Redirect (priority over everything): count <= 0, pointers <= 0, pc <= {redirect_pc[31:2], 2'b00}; no push that cycle. A pop completing in the redirect cycle counts as delivered to decode; all other queued entries are discarded.
- id_valid = (count != 0); id_instr/id_pc driven from head entry, forced to 0 when empty.
- Pointers wrap modulo QUEUE_DEPTH.
- No instruction is ever dropped or duplicated absent a redirect.

## Timing

- Reset (asynchronous, immediate, no clock needed): pc=RESET_PC, imem_addr=RESET_PC>>2, count=0, id_valid=0, id_instr=0, id_pc=0.
- First rising edge after rst_n deasserts: pushes instruction at RESET_PC; id_valid=1 after that edge.
- Fetch-to-decode latency: 1 cycle (instruction sampled at edge N is visible at id outputs after edge N).
- Steady state with id_ready=1: one instruction per cycle, consecutive PCs.
- Redirect asserted in cycle N: after edge N, id_valid=0 and imem_addr=target>>2; after edge N+1, id_valid=1 with id_pc=target. Redirect penalty: 1 bubble cycle.
- Back-to-back redirects: each overrides the previous; only the last target is fetched.
- id_ready=0 with queue full: pc, imem_addr, and id outputs stable until a pop.
- Reset asserted mid-operation: all state returns to reset values immediately; queued entries are lost.

## Test plan

- Reset release with RESET_PC=0, imem words 0..3 = 32'h00500093, 32'h00608113, 32'h002081B3, 32'h00000013, and id_ready=1 -> id_pc 0,4,8,12 on consecutive cycles with matching id_instr; id_valid continuous from the first edge.
- Backpressure, QUEUE_DEPTH=2: id_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds at 2, id_pc holds 0. Then id_ready=1 -> id_pc sequence 0,4,8,12 with no gap, drop, or duplicate.
- Redirect while full: redirect_valid=1, redirect_pc=32'h20 -> next cycle id_valid=0, imem_addr=8; following cycle id_valid=1, id_pc=32'h20. Older entries never appear.
- Misaligned target redirect_pc=32'h23, plus simultaneous pop in the redirect cycle -> popped entry delivered once; next fetched id_pc=32'h20.
- rst_n pulled low mid-stream between clock edges -> id_valid, id_instr, id_pc go to 0 and imem_addr to RESET_PC>>2 without waiting for a clock edge; restart matches scenario 1.
- RESET_PC=32'hFFFF_FFFC with id_ready=1 -> id_pc FFFFFFFC followed by 00000000; imem_addr 32'h3FFFFFFF then 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage of the RISC-V front end. Owns the PC, presents the word
//   address to a combinational instruction memory, and buffers fetched
//   {pc, instr} pairs in a small circular queue that feeds decode over a
//   valid/ready handshake. An execute redirect flushes the queue and reloads
//   the PC.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr         word index to instruction memory (pc >> 2)
//   imem_rdata        instruction word for imem_addr, same cycle
//   redirect_valid    execute redirect request
//   redirect_pc       redirect target byte address (low 2 bits ignored)
//   id_valid          queue head is valid
//   id_ready          decode accepts head this cycle
//   id_instr, id_pc   head instruction and its byte PC (0 when empty)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic        pop, fetch_en;
  logic [31:0] target;

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;
  // A pop frees a slot in the same cycle, so a full queue still fetches
  // when decode is draining it.
  assign fetch_en = !redirect_valid & ((count < CW'(QUEUE_DEPTH)) | pop);
  // Mask rather than slice so every redirect_pc bit is consumed.
  assign target   = redirect_pc & ~32'h3;

  assign imem_addr = pc >> 2;
  assign id_instr  = id_valid ? q_instr[rd_ptr] : '0;
  assign id_pc     = id_valid ? q_pc[rd_ptr]    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // Redirect wins: any pop this cycle has already been consumed by
      // decode; everything else in the queue is dropped.
      pc     <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch_en) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({fetch_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; visibility is gated by count.
  always_ff @(posedge clk) begin
    if (fetch_en) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance with RESET_PC=0 and a
// second with RESET_PC=FFFF_FFFC for PC wrap. Inputs change #1 after the
// rising edge; outputs are sampled there too.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_instr, id_pc;

  logic [31:0] w_imem_addr, w_imem_rdata, w_id_instr, w_id_pc;
  logic        w_id_valid;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_id_ready = 1'b1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0050_0093;
      32'd1:   return 32'h0060_8113;
      32'd2:   return 32'h0020_81B3;
      32'd3:   return 32'h0000_0013;
      default: return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  assign imem_rdata   = imem_word(imem_addr);
  assign w_imem_rdata = imem_word(w_imem_addr);

  instr_fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc));

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .id_valid(w_id_valid), .id_ready(w_id_ready), .id_instr(w_id_instr), .id_pc(w_id_pc));

  task automatic edge1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    redirect_valid = 1'b0; id_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0; #1;
    total++; if ({id_valid, id_instr, id_pc, imem_addr} !== 97'b0)
      $display("FAIL reset_outputs got v=%b i=%h p=%h a=%h want all 0", id_valid, id_instr, id_pc, imem_addr);
    else passed++;
    total++; if (w_imem_addr !== 32'h3FFF_FFFF || w_id_valid !== 1'b0)
      $display("FAIL reset_wrap_addr got a=%h v=%b want 3fffffff 0", w_imem_addr, w_id_valid);
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Assumes reset just released; fetches 0,4,8,12 with continuous valid.
  task automatic run_stream(input string tag);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      edge1();
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== imem_word(32'(k)))
        $display("FAIL %s[%0d] got v=%b pc=%h instr=%h want 1 %h %h", tag, k,
                 id_valid, id_pc, id_instr, 32'(4*k), imem_word(32'(k)));
      else passed++;
    end
  endtask

  task automatic test_stream;
    do_reset();
    run_stream("stream");
  endtask

  task automatic test_backpressure;
    do_reset();
    repeat (5) edge1();
    total++; if (imem_addr !== 32'd2 || id_pc !== 32'd0 || id_valid !== 1'b1 || id_instr !== 32'h0050_0093)
      $display("FAIL bp_hold got a=%h pc=%h v=%b i=%h want 2 0 1 00500093", imem_addr, id_pc, id_valid, id_instr);
    else passed++;
    id_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      edge1();
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== imem_word(32'(k)))
        $display("FAIL bp_drain[%0d] got v=%b pc=%h want 1 %h", k, id_valid, id_pc, 32'(4*k));
      else passed++;
    end
  endtask

  task automatic test_redirect_full;
    do_reset();
    repeat (3) edge1();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    edge1();
    total++; if (id_valid !== 1'b0 || imem_addr !== 32'd8 || id_pc !== 32'd0 || id_instr !== 32'd0)
      $display("FAIL redir_flush got v=%b a=%h pc=%h i=%h want 0 8 0 0", id_valid, imem_addr, id_pc, id_instr);
    else passed++;
    redirect_valid = 1'b0; id_ready = 1'b1;
    edge1();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== imem_word(32'd8))
      $display("FAIL redir_target got v=%b pc=%h i=%h want 1 20 %h", id_valid, id_pc, id_instr, imem_word(32'd8));
    else passed++;
    edge1();
    total++; if (id_pc !== 32'h24)
      $display("FAIL redir_next got pc=%h want 24", id_pc);
    else passed++;
  endtask

  task automatic test_redirect_misaligned_pop;
    do_reset();
    repeat (3) edge1();
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h23;
    #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h0)
      $display("FAIL mis_pop_head got v=%b pc=%h want 1 0", id_valid, id_pc);
    else passed++;
    edge1();
    total++; if (id_valid !== 1'b0 || imem_addr !== 32'd8)
      $display("FAIL mis_flush got v=%b a=%h want 0 8", id_valid, imem_addr);
    else passed++;
    redirect_valid = 1'b0;
    edge1();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h20)
      $display("FAIL mis_target got v=%b pc=%h want 1 20", id_valid, id_pc);
    else passed++;
    edge1();
    total++; if (id_pc !== 32'h24)
      $display("FAIL mis_next got pc=%h want 24", id_pc);
    else passed++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    id_ready = 1'b1;
    repeat (2) edge1();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    edge1();
    redirect_pc = 32'h80;
    edge1();
    total++; if (id_valid !== 1'b0 || imem_addr !== 32'h20)
      $display("FAIL b2b_flush got v=%b a=%h want 0 20", id_valid, imem_addr);
    else passed++;
    redirect_valid = 1'b0;
    edge1();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h80)
      $display("FAIL b2b_target got v=%b pc=%h want 1 80", id_valid, id_pc);
    else passed++;
  endtask

  task automatic test_async_reset;
    do_reset();
    id_ready = 1'b1;
    repeat (2) edge1();
    @(posedge clk); #3 rst_n = 1'b0; #1;
    total++; if ({id_valid, id_instr, id_pc, imem_addr} !== 97'b0)
      $display("FAIL async_rst got v=%b i=%h p=%h a=%h want all 0", id_valid, id_instr, id_pc, imem_addr);
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    run_stream("restart");
  endtask

  task automatic test_wrap;
    do_reset();
    total++; if (w_imem_addr !== 32'h3FFF_FFFF)
      $display("FAIL wrap_addr0 got %h want 3fffffff", w_imem_addr);
    else passed++;
    edge1();
    total++; if (w_id_valid !== 1'b1 || w_id_pc !== 32'hFFFF_FFFC || w_id_instr !== imem_word(32'h3FFF_FFFF) || w_imem_addr !== 32'd0)
      $display("FAIL wrap_top got v=%b pc=%h i=%h a=%h want 1 fffffffc %h 0", w_id_valid, w_id_pc, w_id_instr, w_imem_addr, imem_word(32'h3FFF_FFFF));
    else passed++;
    edge1();
    total++; if (w_id_pc !== 32'd0 || w_id_instr !== 32'h0050_0093 || w_imem_addr !== 32'd1)
      $display("FAIL wrap_zero got pc=%h i=%h a=%h want 0 00500093 1", w_id_pc, w_id_instr, w_imem_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_misaligned_pop();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
